// File: rtl/seq_shifter_pkg.sv
// Shared types and width helpers for the iterative rotator.
package seq_shifter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int N_DEFAULT = 3;

  function automatic int width_of(input int n);
    return 1 << n;
  endfunction

  function automatic int stage_bits(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/seq_barrel_shifter_bit_reverser.sv
// Combinational 2**N-bit reverse, used on load and unload paths.
module bit_reverser
  import seq_shifter_pkg::*;
#(
  parameter int N = N_DEFAULT
) (
  input  logic [(1<<N)-1:0] din,
  output logic [(1<<N)-1:0] dout
);

  localparam int W = width_of(N);

  always_comb begin
    dout = '0;
    for (int i = 0; i < W; i++)
      dout[i] = din[W-1-i];
  end

endmodule

// File: rtl/seq_barrel_shifter.sv
// Iterative rotator, one log2 stage per clock; left rotate via bit reversal.
// Optional SEQ_SHIFT_EARLY_DONE_EN: leave SHIFT once no higher amt bits remain.
module seq_barrel_shifter
  import seq_shifter_pkg::*;
#(
  parameter int N = N_DEFAULT
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 lr,
  input  logic [N-1:0]         amt,
  input  logic [(1<<N)-1:0]    data_in,
  output logic                 busy,
  output logic                 done,
  output logic [(1<<N)-1:0]    data_out
);

  localparam int W  = width_of(N);
  localparam int SW = stage_bits(N);

  state_t         state;
  logic [W-1:0]   work;
  logic [N-1:0]   amt_r;
  logic           lr_r;
  logic [SW-1:0]  stage;

  logic [W-1:0]   load_rev;
  logic [W-1:0]   unload_rev;
  logic [W-1:0]   rot;
  logic [W-1:0]   work_next;
  logic [N-1:0]   sh;
  logic           last;

  bit_reverser #(.N(N)) u_rev_load (
    .din  (data_in),
    .dout (load_rev)
  );

  bit_reverser #(.N(N)) u_rev_unload (
    .din  (work_next),
    .dout (unload_rev)
  );

  always_comb begin
    sh        = N'(1) << stage;
    rot       = (work >> sh) | (work << (W - int'(sh)));
    work_next = amt_r[stage] ? rot : work;
`ifdef SEQ_SHIFT_EARLY_DONE_EN
    last = (stage == SW'(N-1)) || (((amt_r >> stage) >> 1) == '0);
`else
    last = (stage == SW'(N-1));
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      data_out <= '0;
      work     <= '0;
      amt_r    <= '0;
      lr_r     <= 1'b0;
      stage    <= '0;
    end else begin
      unique case (state)
        IDLE, DONE: begin
          done <= 1'b0;
          if (start) begin
            lr_r  <= lr;
            amt_r <= amt;
            work  <= lr ? data_in : load_rev;
            stage <= '0;
            busy  <= 1'b1;
            state <= SHIFT;
          end else begin
            state <= IDLE;
          end
        end
        SHIFT: begin
          work <= work_next;
          if (last) begin
            data_out <= lr_r ? work_next : unload_rev;
            busy     <= 1'b0;
            done     <= 1'b1;
            state    <= DONE;
          end else begin
            stage <= stage + SW'(1);
          end
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
